free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 7: physical register index width (128 pregs).
REQ-002 SHALL have parameter ROB_WIDTH, default 4: ROB tag width (16 tags, one checkpoint slot per tag).
REQ-003 SHALL have parameter ARCH_REGS, default 32: pregs 0..ARCH_REGS-1 hold the initial architectural mapping and are never initially free.
REQ-004 SHALL have ports clk, in, 1, sole clock; reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_alloc, in, 1, rename requests one preg this cycle.
REQ-006 SHALL have ports o_alloc_preg, out, PREG_WIDTH, preg at the read head, valid when o_empty is low.
REQ-007 SHALL have ports o_empty, out, 1, no free preg available.
REQ-008 SHALL have ports o_free_count, out, PREG_WIDTH+1, number of free pregs.
REQ-009 SHALL have ports i_checkpoint_valid, in, 1, branch dispatched this cycle.
REQ-010 SHALL have ports i_checkpoint_tag, in, ROB_WIDTH, ROB tag of that branch.
REQ-011 SHALL have ports i_release_valid, in, 1, ROB commit this cycle.
REQ-012 SHALL have ports i_release_preg, in, PREG_WIDTH, old preg from commit; value 0 means nothing to free.
REQ-013 SHALL have ports i_branch_mispredict, in, 1, recovery pulse.
REQ-014 SHALL have ports i_mispredict_rob_tag, in, ROB_WIDTH, tag of the mispredicting branch.

Function
REQ-015 SHALL hold free pregs in a circular buffer of 2^PREG_WIDTH entries with read and write pointers of PREG_WIDTH+1 bits; o_free_count = wr_ptr - rd_ptr, modulo 2^(PREG_WIDTH+1).
REQ-016 SHALL drive o_alloc_preg combinationally from buffer[rd_ptr]; o_empty = (o_free_count == 0).
REQ-017 SHALL pop on a clock edge when i_alloc && !o_empty && !i_branch_mispredict; i_alloc while empty SHALL be ignored, with no pointer movement.
REQ-018 SHALL push i_release_preg at wr_ptr on a clock edge when i_release_valid && i_release_preg != 0, including during a mispredict cycle.
REQ-019 SHALL not bypass a release to the allocation path in the same cycle; the released preg becomes visible the next cycle.
REQ-020 SHALL, on i_checkpoint_valid, store in checkpoint[i_checkpoint_tag] the rd_ptr value after this cycle's pop, so the branch's own allocation is preserved.
REQ-021 SHALL, on i_branch_mispredict, set rd_ptr <= checkpoint[i_mispredict_rob_tag] and ignore both i_alloc and i_checkpoint_valid in that cycle.
REQ-022 SHALL leave wr_ptr unaffected by recovery apart from a same-cycle release; regs freed after the checkpoint remain free.
REQ-023 SHALL never overflow: at most 2^PREG_WIDTH - ARCH_REGS pregs are in flight, so the buffer cannot fill. An assertion SHALL flag o_free_count exceeding 2^PREG_WIDTH - ARCH_REGS.
REQ-024 SHALL handle pointer wrap-around via the extra MSB; index = pointer[PREG_WIDTH-1:0].

Reset
REQ-025 SHALL, on reset, load buffer[i] = ARCH_REGS + i for i < 2^PREG_WIDTH - ARCH_REGS, set rd_ptr = 0 and wr_ptr = 2^PREG_WIDTH - ARCH_REGS, and clear all checkpoint slots.
REQ-026 SHALL, after reset, drive o_alloc_preg = ARCH_REGS (32), o_empty = 0 and o_free_count = 96.
REQ-027 SHALL abandon any in-progress alloc, release or checkpoint when reset asserts mid-operation; the reset state wins.

Structure
REQ-028 SHALL place PREG_WIDTH, ROB_WIDTH, ARCH_REGS defaults and a preg_t typedef in the shared core package, which rename and rob also use.
REQ-029 SHALL be flat, with no sub-module; the checkpoint table is an internal array of 2^ROB_WIDTH pointers.

Verification
REQ-030 SHALL cover: reset, then 3 allocs -> pregs 32, 33, 34 returned; o_free_count goes 96 -> 93.
REQ-031 SHALL cover: 96 allocs -> o_empty=1, o_free_count=0; a 97th alloc is ignored; release preg 40 -> next cycle o_alloc_preg=40, o_empty=0.
REQ-032 SHALL cover: release with preg 0 -> count unchanged; simultaneous alloc and release of 50 -> count unchanged, 50 not returned that cycle.
REQ-033 SHALL cover: alloc with checkpoint tag 5 (gets 32), 4 more allocs (33..36), mispredict tag 5 -> next o_alloc_preg=33, count restored to 95.
REQ-034 SHALL cover: mispredict with same-cycle release 70 and alloc -> rd_ptr restored, 70 appended, alloc not consumed.
REQ-035 SHALL cover: 300 random alloc/release cycles with pointer wrap -> no duplicate preg outstanding, and count matches the model.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core parameters and types used by rename, rob and the free list.
package core_pkg;

    localparam int PREG_WIDTH = 7;
    localparam int ROB_WIDTH  = 4;
    localparam int ARCH_REGS  = 32;

    typedef logic [PREG_WIDTH-1:0] preg_t;

    // Number of pregs available for renaming once the architectural map is reserved.
    function automatic int num_free_pregs(input int preg_width, input int arch_regs);
        return (1 << preg_width) - arch_regs;
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular buffer with per-ROB-tag read-pointer checkpoints.
// Allocation is visible combinationally at the head; releases appear the following cycle.
module free_list
    import core_pkg::*;
#(
    parameter int PREG_WIDTH = core_pkg::PREG_WIDTH,
    parameter int ROB_WIDTH  = core_pkg::ROB_WIDTH,
    parameter int ARCH_REGS  = core_pkg::ARCH_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_alloc,
    output logic [PREG_WIDTH-1:0] o_alloc_preg,
    output logic                  o_empty,
    output logic [PREG_WIDTH:0]   o_free_count,
    input  logic                  i_checkpoint_valid,
    input  logic [ROB_WIDTH-1:0]  i_checkpoint_tag,
    input  logic                  i_release_valid,
    input  logic [PREG_WIDTH-1:0] i_release_preg,
    input  logic                  i_branch_mispredict,
    input  logic [ROB_WIDTH-1:0]  i_mispredict_rob_tag
);

    localparam int DEPTH    = 1 << PREG_WIDTH;
    localparam int NUM_TAGS = 1 << ROB_WIDTH;
    localparam int PTR_W    = PREG_WIDTH + 1;
    localparam int FREE     = num_free_pregs(PREG_WIDTH, ARCH_REGS);

    typedef logic [PREG_WIDTH-1:0] idx_t;
    typedef logic [PTR_W-1:0]      ptr_t;

    idx_t fl_q   [DEPTH];
    idx_t fl_d   [DEPTH];
    ptr_t ckpt_q [NUM_TAGS];
    ptr_t ckpt_d [NUM_TAGS];
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;

    ptr_t count;
    ptr_t rd_after_pop;
    logic pop;
    logic push;

    always_comb begin
        count        = wr_ptr_q - rd_ptr_q;
        pop          = i_alloc && (count != '0) && !i_branch_mispredict;
        push         = i_release_valid && (i_release_preg != '0);
        rd_after_pop = rd_ptr_q + ptr_t'(pop);

        rd_ptr_d = i_branch_mispredict ? ckpt_q[i_mispredict_rob_tag] : rd_after_pop;
        wr_ptr_d = wr_ptr_q + ptr_t'(push);

        fl_d = fl_q;
        if (push) begin
            fl_d[wr_ptr_q[PREG_WIDTH-1:0]] = i_release_preg;
        end

        // The checkpoint captures the pointer past the branch's own allocation.
        ckpt_d = ckpt_q;
        if (i_checkpoint_valid && !i_branch_mispredict) begin
            ckpt_d[i_checkpoint_tag] = rd_after_pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= ptr_t'(FREE);
            for (int i = 0; i < DEPTH; i++) begin
                fl_q[i] <= (i < FREE) ? idx_t'(ARCH_REGS + i) : '0;
            end
            for (int t = 0; t < NUM_TAGS; t++) begin
                ckpt_q[t] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fl_q     <= fl_d;
            ckpt_q   <= ckpt_d;
        end
    end

    assign o_alloc_preg = fl_q[rd_ptr_q[PREG_WIDTH-1:0]];
    assign o_free_count = count;
    assign o_empty      = (count == '0);

    // More free pregs than exist outside the architectural map means a double release.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        o_free_count <= ptr_t'(FREE));

endmodule

// File: tb/tb_free_list.sv
// Directed vector table plus hand-written recovery, empty, reset and random sequences.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_alloc;
    logic [6:0] o_alloc_preg;
    logic       o_empty;
    logic [7:0] o_free_count;
    logic       i_checkpoint_valid;
    logic [3:0] i_checkpoint_tag;
    logic       i_release_valid;
    logic [6:0] i_release_preg;
    logic       i_branch_mispredict;
    logic [3:0] i_mispredict_rob_tag;

    int total = 0;
    int bad   = 0;

    free_list dut (
        .clk                  (clk),
        .reset                (reset),
        .i_alloc              (i_alloc),
        .o_alloc_preg         (o_alloc_preg),
        .o_empty              (o_empty),
        .o_free_count         (o_free_count),
        .i_checkpoint_valid   (i_checkpoint_valid),
        .i_checkpoint_tag     (i_checkpoint_tag),
        .i_release_valid      (i_release_valid),
        .i_release_preg       (i_release_preg),
        .i_branch_mispredict  (i_branch_mispredict),
        .i_mispredict_rob_tag (i_mispredict_rob_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       alloc;
        logic       ckv;
        logic [3:0] ckt;
        logic       relv;
        logic [6:0] relp;
        logic       misp;
        logic [3:0] mtag;
        logic [6:0] exp_preg;
        logic       exp_empty;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic a, input logic ckv, input int ckt,
                                input logic relv, input int relp,
                                input logic misp, input int mtag,
                                input int ep, input logic ee, input int ec);
        vec_t v;
        v.alloc = a;     v.ckv = ckv;      v.ckt = 4'(ckt);
        v.relv = relv;   v.relp = 7'(relp);
        v.misp = misp;   v.mtag = 4'(mtag);
        v.exp_preg = 7'(ep); v.exp_empty = ee; v.exp_cnt = 8'(ec);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_alloc = 0; i_checkpoint_valid = 0; i_checkpoint_tag = 0;
        i_release_valid = 0; i_release_preg = 0;
        i_branch_mispredict = 0; i_mispredict_rob_tag = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
    endtask

    logic [6:0] free_q[$];
    logic [6:0] out_q[$];

    initial begin
        reset = 1;
        idle_inputs();
        #12;
        reset = 0;
        #1;

        check("reset_preg",  o_alloc_preg, 32);
        check("reset_empty", o_empty, 0);
        check("reset_count", o_free_count, 96);

        // Table: alloc, release-0, alloc+release, checkpoint, mispredict with alloc/release.
        vecs[0]  = mk(0,0,0, 0,0,  0,0, 32,0,96);
        vecs[1]  = mk(1,0,0, 0,0,  0,0, 32,0,96);
        vecs[2]  = mk(1,0,0, 0,0,  0,0, 33,0,95);
        vecs[3]  = mk(1,0,0, 0,0,  0,0, 34,0,94);
        vecs[4]  = mk(0,0,0, 1,0,  0,0, 35,0,93);
        vecs[5]  = mk(1,0,0, 1,50, 0,0, 35,0,93);
        vecs[6]  = mk(0,0,0, 0,0,  0,0, 36,0,93);
        vecs[7]  = mk(1,1,5, 0,0,  0,0, 36,0,93);
        vecs[8]  = mk(1,0,0, 0,0,  0,0, 37,0,92);
        vecs[9]  = mk(1,0,0, 0,0,  0,0, 38,0,91);
        vecs[10] = mk(1,0,0, 0,0,  0,0, 39,0,90);
        vecs[11] = mk(1,0,0, 0,0,  0,0, 40,0,89);
        vecs[12] = mk(1,0,0, 0,0,  1,5, 41,0,88);
        vecs[13] = mk(0,0,0, 0,0,  0,0, 37,0,92);
        vecs[14] = mk(1,1,6, 1,70, 1,5, 37,0,92);
        vecs[15] = mk(0,0,0, 0,0,  0,0, 37,0,93);
        vecs[16] = mk(1,0,0, 0,0,  0,0, 37,0,93);
        vecs[17] = mk(0,0,0, 0,0,  0,0, 38,0,92);

        for (int k = 0; k < 18; k++) begin
            i_alloc = vecs[k].alloc;
            i_checkpoint_valid = vecs[k].ckv;  i_checkpoint_tag = vecs[k].ckt;
            i_release_valid = vecs[k].relv;    i_release_preg = vecs[k].relp;
            i_branch_mispredict = vecs[k].misp; i_mispredict_rob_tag = vecs[k].mtag;
            #1;
            check($sformatf("vec%0d_preg", k),  o_alloc_preg, vecs[k].exp_preg);
            check($sformatf("vec%0d_empty", k), o_empty,      vecs[k].exp_empty);
            check($sformatf("vec%0d_count", k), o_free_count, vecs[k].exp_cnt);
            tick();
        end

        // Checkpoint on first alloc, four more allocs, then recover.
        do_reset();
        i_alloc = 1; i_checkpoint_valid = 1; i_checkpoint_tag = 5;
        check("ckpt_alloc_preg", o_alloc_preg, 32);
        tick();
        for (int k = 0; k < 4; k++) begin
            i_alloc = 1;
            check($sformatf("ckpt_more%0d", k), o_alloc_preg, 33 + k);
            tick();
        end
        check("ckpt_count_before", o_free_count, 91);
        i_branch_mispredict = 1; i_mispredict_rob_tag = 5;
        tick();
        check("recover_preg",  o_alloc_preg, 33);
        check("recover_count", o_free_count, 95);

        // Drain to empty, ignored alloc, then release refills without bypass.
        do_reset();
        for (int k = 0; k < 96; k++) begin
            i_alloc = 1;
            if (o_alloc_preg !== 7'(32 + k)) check($sformatf("drain%0d", k), o_alloc_preg, 32 + k);
            tick();
        end
        check("drained_empty", o_empty, 1);
        check("drained_count", o_free_count, 0);
        i_alloc = 1;
        tick();
        check("empty_alloc_count", o_free_count, 0);
        i_release_valid = 1; i_release_preg = 40; i_alloc = 1;
        #1;
        check("no_bypass_empty", o_empty, 1);
        tick();
        check("refill_preg",  o_alloc_preg, 40);
        check("refill_empty", o_empty, 0);
        check("refill_count", o_free_count, 1);

        // Reset asserted mid-cycle abandons alloc, release and checkpoint.
        do_reset();
        i_alloc = 1; tick();
        i_alloc = 1; tick();
        i_alloc = 1; i_release_valid = 1; i_release_preg = 90;
        i_checkpoint_valid = 1; i_checkpoint_tag = 5;
        #2;
        reset = 1;
        #1;
        check("async_reset_preg", o_alloc_preg, 32);
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        #1;
        check("midrst_preg",  o_alloc_preg, 32);
        check("midrst_count", o_free_count, 96);
        i_alloc = 1; tick();
        i_branch_mispredict = 1; i_mispredict_rob_tag = 5; tick();
        check("midrst_ckpt_cleared_preg",  o_alloc_preg, 32);
        check("midrst_ckpt_cleared_count", o_free_count, 96);

        // Random alloc/release against a queue model; pointers wrap.
        do_reset();
        free_q.delete();
        out_q.delete();
        for (int p = 32; p < 128; p++) free_q.push_back(7'(p));
        for (int c = 0; c < 300; c++) begin
            logic       do_alloc;
            logic       do_rel;
            logic [6:0] relp;
            int         idx;
            int         dup;
            do_alloc = ($urandom_range(0, 99) < 55);
            do_rel   = (out_q.size() > 0) && ($urandom_range(0, 99) < 50);
            relp = 0;
            if (do_rel) begin
                idx  = $urandom_range(0, out_q.size() - 1);
                relp = out_q[idx];
                out_q.delete(idx);
            end
            check($sformatf("rnd%0d_count", c), o_free_count, free_q.size());
            if (free_q.size() > 0) begin
                check($sformatf("rnd%0d_preg", c), o_alloc_preg, free_q[0]);
                if (do_alloc) begin
                    dup = 0;
                    foreach (out_q[j]) if (out_q[j] == o_alloc_preg) dup = 1;
                    check($sformatf("rnd%0d_dup", c), dup, 0);
                    out_q.push_back(free_q.pop_front());
                end
            end
            if (do_rel) free_q.push_back(relp);
            i_alloc = do_alloc; i_release_valid = do_rel; i_release_preg = relp;
            tick();
        end
        check("rnd_final_count", o_free_count, free_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
